// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit with HI/LO registers and busy handshake
//
// Purpose: multi-cycle mult/multu (and, with MD_DIV_EN defined, div/divu)
// producing {HI,LO}, plus single-cycle mthi/mtlo writes.
//
// Optional feature macro: MD_DIV_EN (enables div/divu; default build has no divider).
//
// Parameters:
//   MULT_CYCLES - busy cycles for mult/multu
//   DIV_CYCLES  - busy cycles for div/divu
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-low reset
//   start  - issue strobe qualifying md_op
//   md_op  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A, B   - forwarded rs / rt operands
//   busy   - operation in progress
//   HI, LO - result registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic          sgn_q, sgn_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;

    logic op_mul;
    logic op_div;
    logic op_signed;

    assign op_mul    = (md_op == 3'd1) || (md_op == 3'd2);
    assign op_signed = (md_op == 3'd1) || (md_op == 3'd3);
`ifdef MD_DIV_EN
    assign op_div    = (md_op == 3'd3) || (md_op == 3'd4);
`else
    assign op_div    = 1'b0;
`endif

    // Products from the latched operands only.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] prod;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign prod   = sgn_q ? prod_s : prod_u;

`ifdef MD_DIV_EN
    // Signed division is done on magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0 instead of overflowing.
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign a_mag  = (sgn_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign b_mag  = (sgn_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    // Divide-by-zero results are discarded; substitute 1 to keep the divider defined.
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
    assign rem    = (sgn_q && a_q[31]) ? (32'd0 - r_mag) : r_mag;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_mul) begin
                        a_d     = A;
                        b_d     = B;
                        sgn_d   = op_signed;
                        cnt_d   = CW'(MULT_CYCLES);
                        state_d = MUL;
                        busy_d  = 1'b1;
                    end else if (op_div) begin
                        a_d     = A;
                        b_d     = B;
                        sgn_d   = op_signed;
                        cnt_d   = CW'(DIV_CYCLES);
                        state_d = DIV;
                        busy_d  = 1'b1;
                    end else if (md_op == 3'd5) begin
                        hi_d = A;
                    end else if (md_op == 3'd6) begin
                        lo_d = A;
                    end
                end
            end
            MUL: begin
                // Finishing edge is the one that takes the counter from 1 to 0.
                if (cnt_q <= CW'(1)) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DIV: begin
                if (cnt_q <= CW'(1)) begin
`ifdef MD_DIV_EN
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
`endif
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit (vector table, corner sequences, random vs model)
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

`ifdef MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op from idle, then count busy cycles while scrambling A/B and
    // throwing random start/md_op at the unit. hold_ok reports HI/LO stayed put.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output bit hold_ok);
        logic [31:0] h0;
        logic [31:0] l0;
        @(negedge clk);
        h0    = HI;
        l0    = LO;
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start   = 1'b0;
        md_op   = 3'd0;
        cyc     = 0;
        hold_ok = 1'b1;
        while (busy && cyc < 200) begin
            cyc++;
            if (HI !== h0 || LO !== l0) hold_ok = 1'b0;
            start = 1'($urandom_range(0, 1));
            md_op = 3'($urandom);
            A     = $urandom;
            B     = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        md_op = 3'd0;
    endtask

    // Reference behaviour from the instruction semantics, using 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cyc = 0;
        case (op)
            3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; cyc = MC; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; cyc = MC; end
            3'd3, 3'd4: begin
                if (DIV_EN) begin
                    cyc = DC;
                    if (op == 3'd4) begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    if (b != 32'd0) begin
                        q = sa / sb;
                        r = sa % sb;
                        m_lo = q[31:0];
                        m_hi = r[31:0];
                    end
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    initial begin
        int  cyc;
        int  mcyc;
        bit  hold_ok;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;

        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b1;
        m_hi  = 32'd0;
        m_lo  = 32'd0;

        // Vector table.
        vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'd2, 32'h5, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFFE, MC});
        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'd2, 32'h5, 32'h6, 32'h00000001, 32'hFFFFFFFE, MC});
        vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h0, 32'h1, MC});
        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h6, 32'hFFFFFFFE, 32'h00000001, MC});
        vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h5, 32'h6, 32'h40000000, 32'h0, MC});
        vecs.push_back('{3'd5, 32'h1234, 32'h0, 32'h5, 32'h6, 32'h1234, 32'h6, 0});
        vecs.push_back('{3'd6, 32'hBEEF, 32'h0, 32'h5, 32'h6, 32'h5, 32'hBEEF, 0});
        vecs.push_back('{3'd0, 32'h77, 32'h3, 32'h5, 32'h6, 32'h5, 32'h6, 0});
        vecs.push_back('{3'd7, 32'h77, 32'h3, 32'h5, 32'h6, 32'h5, 32'h6, 0});
`ifdef MD_DIV_EN
        vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'd2, 32'h5, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFFD, DC});
        vecs.push_back('{3'd4, 32'd7, 32'd2, 32'h5, 32'h6, 32'h1, 32'h3, DC});
        vecs.push_back('{3'd3, 32'h12345678, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, DC});
        vecs.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h0, 32'h80000000, DC});
        vecs.push_back('{3'd3, 32'd7, 32'hFFFFFFFE, 32'h5, 32'h6, 32'h1, 32'hFFFFFFFD, DC});
`else
        vecs.push_back('{3'd3, 32'd7, 32'd2, 32'hAA, 32'hBB, 32'hAA, 32'hBB, 0});
        vecs.push_back('{3'd4, 32'd7, 32'd2, 32'hAA, 32'hBB, 32'hAA, 32'hBB, 0});
`endif

        foreach (vecs[i]) begin
            run_op(3'd5, vecs[i].pre_hi, 32'd0, cyc, hold_ok);
            run_op(3'd6, vecs[i].pre_lo, 32'd0, cyc, hold_ok);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, hold_ok);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("vec%0d_hi", i), HI, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), LO, vecs[i].exp_lo);
            if (cyc > 0) check($sformatf("vec%0d_hold", i), {31'd0, hold_ok}, 32'd1);
        end

        // mtlo issued while busy is ignored.
        run_op(3'd6, 32'h0000C0DE, 32'd0, cyc, hold_ok);
        @(negedge clk);
        start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b1; md_op = 3'd6; A = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        check("mtlo_busy_lo", LO, 32'h0000C0DE);
        check("mtlo_busy_busy", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (busy && cyc < 200) begin cyc++; @(negedge clk); end
        check("mtlo_busy_final_lo", LO, 32'd12);

        // Reset on the third busy cycle of a mult aborts it.
        run_op(3'd5, 32'h99, 32'd0, cyc, hold_ok);
        @(negedge clk);
        start = 1'b1; md_op = 3'd1; A = 32'd6; B = 32'd7;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        start = 1'b1; md_op = 3'd6; A = 32'h55;
        @(negedge clk);
        check("rst_abort_busy", {31'd0, busy}, 32'd0);
        check("rst_abort_hi", HI, 32'd0);
        check("rst_abort_lo", LO, 32'd0);
        reset = 1'b1;
        start = 1'b1; md_op = 3'd2; A = 32'd9; B = 32'd11;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        check("rst_new_busy", {31'd0, busy}, 32'd1);
        cyc = 1;
        @(negedge clk);
        while (busy && cyc < 200) begin cyc++; @(negedge clk); end
        check("rst_new_cycles", 32'(cyc), 32'(MC));
        check("rst_new_lo", LO, 32'd99);
        check("rst_new_hi", HI, 32'd0);
        m_hi = HI === 32'd0 ? 32'd0 : 32'd0;
        m_lo = 32'd99;

        // Random ops against the reference model.
        for (int k = 0; k < 60; k++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            model(rop, ra, rb, mcyc);
            run_op(rop, ra, rb, cyc, hold_ok);
            check($sformatf("rnd%0d_op%0d_cycles", k, rop), 32'(cyc), 32'(mcyc));
            check($sformatf("rnd%0d_op%0d_hi", k, rop), HI, m_hi);
            check($sformatf("rnd%0d_op%0d_lo", k, rop), LO, m_lo);
            if (cyc > 0) check($sformatf("rnd%0d_hold", k), {31'd0, hold_ok}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: E-stage issue strobe qualifying md_op.
REQ-006 SHALL have port md_op, input, 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
REQ-007 SHALL have port A, input, 32: forwarded rs value (V1_E).
REQ-008 SHALL have port B, input, 32: forwarded rt value (V2_E).
REQ-009 SHALL have port busy, output, 1: operation in progress.
REQ-010 SHALL have port HI, output, 32: HI register, feeds HI_E pipeline path to write-back select.
REQ-011 SHALL have port LO, output, 32: LO register, feeds LO_E pipeline path to write-back select.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, plus a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 SHALL, in IDLE with start=1 and md_op in {1,2}, latch A and B, load counter=MULT_CYCLES, enter MUL.
REQ-014 SHALL, in IDLE with start=1 and md_op in {3,4}, latch A and B, load counter=DIV_CYCLES, enter DIV.
REQ-015 SHALL drive busy=1 exactly while state is MUL or DIV: from the cycle after the start edge, for N cycles.
REQ-016 SHALL decrement counter each cycle in MUL/DIV; on the edge where counter reaches 0, write HI/LO, return to IDLE, busy=0 next cycle.
REQ-017 SHALL compute mult as signed 32x32->64 {HI,LO}, and multu as unsigned.
REQ-018 SHALL compute div/divu as LO=quotient, HI=remainder; signed quotient truncates toward zero; remainder takes dividend's sign.
REQ-019 SHALL, for divisor 0, leave HI and LO unchanged but still hold busy for DIV_CYCLES.
REQ-020 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000, HI=0.
REQ-021 SHALL, in IDLE, on start=1 with md_op=5, write HI=A at that edge; with md_op=6, write LO=A; busy stays 0.
REQ-022 SHALL ignore start (any md_op) while busy=1; the D-stage stall logic is responsible for holding such instructions.
REQ-023 SHALL ignore start with md_op 0 or 7.
REQ-024 SHALL hold HI/LO stable during MUL/DIV; results become visible only on completion.
REQ-025 SHALL use only operands latched at start; A/B changes during busy have no effect.

Reset
REQ-026 SHALL, on a clk edge with reset=0, set HI=0, LO=0, busy=0, counter=0, state=IDLE.
REQ-027 SHALL let reset abort an in-flight MUL/DIV with no HI/LO write.
REQ-028 SHALL give reset priority over a simultaneous start.

Configuration
REQ-029 SHALL, with MD_DIV_EN defined, implement div/divu per REQ-014, REQ-018 to REQ-020.
REQ-030 SHALL, without MD_DIV_EN, treat md_op 3/4 as none: no state change, busy stays 0, HI/LO unchanged, no divider logic synthesized.

Verification
REQ-031 SHALL cover: mult A=0xFFFFFFFF, B=2 -> busy 1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x1, LO=0xFFFFFFFE.
REQ-032 SHALL cover: div A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-033 SHALL cover: HI=0x11, LO=0x22, then div by B=0 -> busy 10 cycles, HI=0x11, LO=0x22 after completion.
REQ-034 SHALL cover: mthi A=0x1234 -> HI=0x1234 next cycle, busy never 1; mtlo issued during busy -> LO unchanged.
REQ-035 SHALL cover: reset=0 on 3rd busy cycle of mult -> next cycle busy=0, HI=LO=0; new mult accepted the following cycle.
REQ-036 SHALL cover: build without MD_DIV_EN, start div A=7, B=2 -> busy stays 0, HI/LO unchanged.
